// File: rtl/encoder_ctrl_pkg.sv
// Shared types and default constants for the encoder frame controller.
package encoder_ctrl_pkg;

    localparam int DATA_W     = 16;
    localparam int IMG_PIXELS = 100;
    localparam int OUT_N      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        HOLD    = 2'd3
    } enc_state_t;

    typedef logic signed [DATA_W-1:0] enc_result_t [OUT_N];

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/enc_pixel_counter.sv
// Up-counter with synchronous clear and enable. tc flags the last count
// before TERM, so the increment that would reach TERM is known one beat early.
module enc_pixel_counter #(
    parameter int W    = 8,
    parameter int TERM = 100
) (
    input  logic clk_p,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;

    // Count register; clear has priority over enable.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc = (cnt_q == W'(TERM - 1));

endmodule

// File: rtl/encoder_frame_ctrl.sv
// Frame-level controller for the stride-2 convolution encoder datapath.
// Counts one image of pixels into the datapath, brackets the frame with
// dp_start/dp_abort, latches the datapath result and hands it downstream.
// Optional watchdog in COMPUTE is enabled by defining ENC_CTRL_TIMEOUT_EN.
module encoder_frame_ctrl #(
    parameter int DATA_W         = encoder_ctrl_pkg::DATA_W,
    parameter int IMG_PIXELS     = encoder_ctrl_pkg::IMG_PIXELS,
    parameter int OUT_N          = encoder_ctrl_pkg::OUT_N,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_p,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     dp_start,
    output logic                     dp_abort,
    output logic signed [DATA_W-1:0] dp_pixel,
    output logic                     dp_pixel_valid,
    input  logic                     dp_done,
    input  logic signed [DATA_W-1:0] dp_result [OUT_N],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data [OUT_N],
    output logic                     err_len,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic [15:0]              frames_done
);

    import encoder_ctrl_pkg::*;

    // One width serves both counters so the two instances stay alike.
    localparam int CNT_W = cnt_width((IMG_PIXELS > TIMEOUT_CYCLES) ? IMG_PIXELS : TIMEOUT_CYCLES);

    enc_state_t state_q, state_d;

    logic accept;
    logic pix_tc;
    logic pix_clr;
    logic set_len;
    logic abort_d;
    logic capture;
    logic deliver;

    logic signed [DATA_W-1:0] pix_p1;
    logic                     vld_p1;
    logic                     start_p1;
    logic                     abort_p1;

    logic        err_len_q;
    logic [15:0] frames_q;

    // in_ready depends on state alone; reset_n gating keeps it low while the
    // block is held in reset.
    assign in_ready  = reset_n && ((state_q == IDLE) || (state_q == LOAD));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);

    enc_pixel_counter #(
        .W    (CNT_W),
        .TERM (IMG_PIXELS)
    ) u_pix_cnt (
        .clk_p   (clk_p),
        .reset_n (reset_n),
        .clr     (pix_clr),
        .en      (accept),
        .tc      (pix_tc)
    );

`ifdef ENC_CTRL_TIMEOUT_EN
    logic wd_run;
    logic wd_tc;
    logic set_to;
    logic err_to_q;

    // The watchdog only counts while waiting for the datapath and is cleared
    // in every other state, so each COMPUTE entry starts from zero.
    assign wd_run = (state_q == COMPUTE);

    enc_pixel_counter #(
        .W    (CNT_W),
        .TERM (TIMEOUT_CYCLES)
    ) u_wd_cnt (
        .clk_p   (clk_p),
        .reset_n (reset_n),
        .clr     (~wd_run),
        .en      (wd_run),
        .tc      (wd_tc)
    );

    // Sticky watchdog flag; a same-cycle clear beats a new set.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            err_to_q <= 1'b0;
        end else if (err_clr) begin
            err_to_q <= 1'b0;
        end else if (set_to) begin
            err_to_q <= 1'b1;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        pix_clr = 1'b0;
        set_len = 1'b0;
        abort_d = 1'b0;
        capture = 1'b0;
        deliver = 1'b0;
`ifdef ENC_CTRL_TIMEOUT_EN
        set_to  = 1'b0;
`endif
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (pix_tc) begin
                        // Final pixel of the image: length is right only if
                        // the source also marked it last.
                        state_d = COMPUTE;
                        pix_clr = 1'b1;
                        set_len = ~in_last;
                    end else if (in_last) begin
                        // Short frame: tell the datapath to drop it.
                        state_d = IDLE;
                        pix_clr = 1'b1;
                        set_len = 1'b1;
                        abort_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            COMPUTE: begin
                if (dp_done) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
`ifdef ENC_CTRL_TIMEOUT_EN
                else if (wd_tc) begin
                    abort_d = 1'b1;
                    set_to  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p1: accepted pixel and frame strobes towards the datapath ----
    // One register between pixel acceptance and the datapath.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            pix_p1   <= '0;
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            abort_p1 <= 1'b0;
        end else begin
            vld_p1   <= accept;
            start_p1 <= accept && (state_q == IDLE);
            abort_p1 <= abort_d;
            if (accept) begin
                pix_p1 <= in_data;
            end
        end
    end

    assign dp_pixel       = pix_p1;
    assign dp_pixel_valid = vld_p1;
    assign dp_start       = start_p1;
    assign dp_abort       = abort_p1;

    // Result latch: captured once per frame and held stable through HOLD.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUT_N; i++) begin
                out_data[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < OUT_N; i++) begin
                out_data[i] <= dp_result[i];
            end
        end
    end

    // Sticky frame-length flag; a same-cycle clear beats a new set.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            err_len_q <= 1'b0;
        end else if (err_clr) begin
            err_len_q <= 1'b0;
        end else if (set_len) begin
            err_len_q <= 1'b1;
        end
    end

    assign err_len = err_len_q;

    // Delivered-frame counter, free-running wrap at 16 bits.
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            frames_q <= '0;
        end else if (deliver) begin
            frames_q <= frames_q + 16'd1;
        end
    end

    assign frames_done = frames_q;

endmodule
